// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared stall-bus layout, slot-control enum and small
// helper functions for the decode-stage operand front end.
package id_operand_stage_pkg;

    // Stall bus layout: bit1 holds the ID slot, bit2 holds the EX slot.
    localparam int   STALL_W_DEF  = 6;
    localparam int   STALL_ID_BIT = 1;
    localparam int   STALL_EX_BIT = 2;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    // MSB of the first source-register field in the instruction word;
    // later ports take the next field down.
    localparam int   RS_MSB       = 25;

    // What the ID pipeline register does on the next clock edge.
    typedef enum logic [1:0] {
        SLOT_LOAD   = 2'd0,
        SLOT_BUBBLE = 2'd1,
        SLOT_HOLD   = 2'd2
    } slot_act_e;

    // Decode the two stall bits that govern the ID slot.
    function automatic slot_act_e slot_action(input logic stall_id, input logic stall_ex);
        slot_act_e act;
        if (stall_id == NO_STOP) begin
            act = SLOT_LOAD;
        end else if (stall_ex == STOP) begin
            act = SLOT_HOLD;
        end else begin
            act = SLOT_BUBBLE;
        end
        return act;
    endfunction

    // 32-bit increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// id_operand_stage_fwd_mux: resolves one read port against the forwarding
// sources. Source 0 is the youngest producer and has the highest priority;
// a matching producer whose data is not ready makes the port pending.
module id_operand_stage_fwd_mux
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 3
) (
    input  logic [REG_AW-1:0]         addr_i,
    input  logic [NUM_SRC-1:0]        we_i,
    input  logic [NUM_SRC*REG_AW-1:0] waddr_i,
    input  logic [NUM_SRC*DATA_W-1:0] wdata_i,
    input  logic [NUM_SRC-1:0]        rdy_i,
    input  logic [DATA_W-1:0]         rf_rdata_i,
    output logic [DATA_W-1:0]         result_o,
    output logic                      pending_o
);

    // Priority search: walk oldest to youngest so the youngest match overrides.
    always_comb begin
        result_o  = rf_rdata_i;
        pending_o = 1'b0;
        if (addr_i == {REG_AW{1'b0}}) begin
            // r0 is hard-wired to zero and never waits on a producer.
            result_o  = {DATA_W{1'b0}};
            pending_o = 1'b0;
        end else begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (we_i[i] && (waddr_i[i*REG_AW +: REG_AW] == addr_i)) begin
                    pending_o = ~rdy_i[i];
                    if (rdy_i[i]) begin
                        result_o = wdata_i[i*DATA_W +: DATA_W];
                    end else begin
                        result_o = {DATA_W{1'b0}};
                    end
                end else begin
                    result_o = result_o;
                end
            end
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID pipeline register, instruction latch across stalls,
// NUM_RD-port priority forwarding and load-use interlock request.
// Optional feature macro: ID_STALL_CNT_EN builds a saturating counter of
// interlock cycles on stall_cnt; without it stall_cnt is constant zero.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_SRC = 3,
    parameter int STALL_W = STALL_W_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [STALL_W-1:0]        stall,
    output logic                      stallreq,
    input  logic                      if_valid,
    input  logic [31:0]               if_pc,
    input  logic [31:0]               inst_sram_rdata,
    output logic [NUM_RD*REG_AW-1:0]  raddr,
    input  logic [NUM_RD*DATA_W-1:0]  rf_rdata,
    input  logic [NUM_RD-1:0]         rd_used,
    input  logic [NUM_SRC-1:0]        fwd_we,
    input  logic [NUM_SRC*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_SRC*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_SRC-1:0]        fwd_rdy,
    output logic                      id_valid,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_inst,
    output logic [NUM_RD*DATA_W-1:0]  opnd,
    output logic [31:0]               stall_cnt
);

    slot_act_e                 slot_act_s;
    logic                      held_s;
    logic                      id_valid_q, id_valid_d;
    logic [31:0]               id_pc_q, id_pc_d;
    logic                      inst_hold_v_q, inst_hold_v_d;
    logic [31:0]               inst_hold_q, inst_hold_d;
    logic [31:0]               id_inst_s;
    logic [NUM_RD*DATA_W-1:0]  res_s;
    logic [NUM_RD-1:0]         pend_s;
    logic [NUM_RD-1:0]         cap_v_q, cap_v_d;
    logic [NUM_RD*DATA_W-1:0]  cap_data_q, cap_data_d;
    logic                      unused_stall_s;

    // Only the ID and EX bits of the shared stall bus matter here.
    assign unused_stall_s = ^stall;

    assign slot_act_s = slot_action(stall[STALL_ID_BIT], stall[STALL_EX_BIT]);
    assign held_s     = (slot_act_s == SLOT_HOLD);

    // ID slot next state: load from IF, insert a bubble, or hold.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        case (slot_act_s)
            SLOT_LOAD: begin
                id_valid_d = if_valid;
                id_pc_d    = if_pc;
            end
            SLOT_BUBBLE: begin
                id_valid_d = 1'b0;
                id_pc_d    = 32'd0;
            end
            default: begin
                id_valid_d = id_valid_q;
                id_pc_d    = id_pc_q;
            end
        endcase
    end

    // Instruction latch: the SRAM word is only valid in the first cycle the
    // slot holds its PC, so keep a copy for the rest of the hold.
    always_comb begin
        inst_hold_v_d = inst_hold_v_q;
        inst_hold_d   = inst_hold_q;
        if (held_s) begin
            if (!inst_hold_v_q) begin
                inst_hold_v_d = 1'b1;
                inst_hold_d   = inst_sram_rdata;
            end else begin
                inst_hold_v_d = 1'b1;
            end
        end else begin
            inst_hold_v_d = 1'b0;
        end
    end

    // Operand capture: freeze each resolved port during a hold, since the
    // producers that supplied it may retire before the hold ends.
    always_comb begin
        cap_v_d    = cap_v_q;
        cap_data_d = cap_data_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (held_s) begin
                if (!cap_v_q[p] && !pend_s[p]) begin
                    cap_v_d[p]                   = 1'b1;
                    cap_data_d[p*DATA_W +: DATA_W] = res_s[p*DATA_W +: DATA_W];
                end else begin
                    cap_v_d[p] = cap_v_q[p];
                end
            end else begin
                cap_v_d[p] = 1'b0;
            end
        end
    end

    // Pipeline, instruction-latch and capture registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'd0;
            inst_hold_v_q <= 1'b0;
            inst_hold_q   <= 32'd0;
            cap_v_q       <= {NUM_RD{1'b0}};
            cap_data_q    <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            inst_hold_v_q <= inst_hold_v_d;
            inst_hold_q   <= inst_hold_d;
            cap_v_q       <= cap_v_d;
            cap_data_q    <= cap_data_d;
        end
    end

    assign id_inst_s = id_valid_q ? (inst_hold_v_q ? inst_hold_q : inst_sram_rdata) : 32'd0;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_s;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        assign raddr[p*REG_AW +: REG_AW] = id_inst_s[RS_MSB - p*REG_AW -: REG_AW];

        id_operand_stage_fwd_mux #(
            .DATA_W  (DATA_W),
            .REG_AW  (REG_AW),
            .NUM_SRC (NUM_SRC)
        ) u_fwd_mux (
            .addr_i     (raddr[p*REG_AW +: REG_AW]),
            .we_i       (fwd_we),
            .waddr_i    (fwd_waddr),
            .wdata_i    (fwd_wdata),
            .rdy_i      (fwd_rdy),
            .rf_rdata_i (rf_rdata[p*DATA_W +: DATA_W]),
            .result_o   (res_s[p*DATA_W +: DATA_W]),
            .pending_o  (pend_s[p])
        );
    end

    // Operand output: captured value wins over live resolution; empty slot reads zero.
    always_comb begin
        opnd = {(NUM_RD*DATA_W){1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            if (id_valid_q) begin
                if (cap_v_q[p]) begin
                    opnd[p*DATA_W +: DATA_W] = cap_data_q[p*DATA_W +: DATA_W];
                end else begin
                    opnd[p*DATA_W +: DATA_W] = res_s[p*DATA_W +: DATA_W];
                end
            end else begin
                opnd[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    assign stallreq = id_valid_q & (|(pend_s & rd_used));

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Interlock counter next state: count every cycle the interlock is raised.
    always_comb begin
        if (stallreq) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Interlock counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: randomized + directed bench for id_operand_stage.
// A behavioural model predicts every cycle's outputs into a queue; a monitor
// pops and compares on the falling edge.
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NS = 3;
    localparam int SW = 6;
    localparam logic [SW-1:0] ST_RUN  = 6'b000000;
    localparam logic [SW-1:0] ST_HOLD = 6'b000110;
    localparam logic [SW-1:0] ST_BUB  = 6'b000010;

    logic              clk = 1'b0;
    logic              resetn;
    logic [SW-1:0]     stall;
    logic              stallreq;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       inst_sram_rdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rf_rdata;
    logic [NR-1:0]     rd_used;
    logic [NS-1:0]     fwd_we;
    logic [NS*AW-1:0]  fwd_waddr;
    logic [NS*DW-1:0]  fwd_wdata;
    logic [NS-1:0]     fwd_rdy;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
    logic [NR*DW-1:0]  opnd;
    logic [31:0]       stall_cnt;

    id_operand_stage dut (
        .clk(clk), .resetn(resetn), .stall(stall), .stallreq(stallreq),
        .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
        .raddr(raddr), .rf_rdata(rf_rdata), .rd_used(rd_used),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .opnd(opnd),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              id_valid;
        logic [31:0]       id_pc;
        logic [31:0]       id_inst;
        logic [NR*AW-1:0]  raddr;
        logic [NR*DW-1:0]  opnd;
        logic              stallreq;
        logic [31:0]       stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: what the slot holds, and the values frozen during a hold.
    bit          m_valid;
    logic [31:0] m_pc;
    bit          m_inst_frozen;
    logic [31:0] m_inst;
    bit          m_op_frozen[NR];
    logic [DW-1:0] m_op[NR];
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h23, rs, rt, 16'h0040};
    endfunction

    // Source register field named by each read port.
    function automatic logic [AW-1:0] port_addr(input logic [31:0] inst, input int p);
        if (p == 0) return inst[25:21];
        return inst[20:16];
    endfunction

    // Operand value for register a on port p: r0 is zero, else the youngest
    // writer of a supplies it (or stalls), else the register file.
    function automatic void resolve(input logic [AW-1:0] a, input int p,
                                    output bit pend, output logic [DW-1:0] val);
        pend = 1'b0;
        val  = rf_rdata[p*DW +: DW];
        if (a == 5'd0) begin
            val = '0;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            if (fwd_we[i] && fwd_waddr[i*AW +: AW] == a) begin
                pend = !fwd_rdy[i];
                val  = fwd_rdy[i] ? fwd_wdata[i*DW +: DW] : '0;
                return;
            end
        end
    endfunction

    function automatic exp_t compute_expected();
        exp_t e;
        bit any_pend;
        bit pd;
        logic [DW-1:0] v;
        logic [AW-1:0] a;
        any_pend   = 1'b0;
        e.id_valid = m_valid;
        e.id_pc    = m_pc;
        e.id_inst  = m_valid ? (m_inst_frozen ? m_inst : inst_sram_rdata) : 32'd0;
        e.raddr    = '0;
        e.opnd     = '0;
        for (int p = 0; p < NR; p++) begin
            a = port_addr(e.id_inst, p);
            e.raddr[p*AW +: AW] = a;
            resolve(a, p, pd, v);
            if (pd && rd_used[p]) any_pend = 1'b1;
            if (m_valid) e.opnd[p*DW +: DW] = m_op_frozen[p] ? m_op[p] : v;
        end
        e.stallreq = m_valid && any_pend;
`ifdef ID_STALL_CNT_EN
        e.stall_cnt = m_cnt;
`else
        e.stall_cnt = 32'd0;
`endif
        return e;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0; m_pc = 32'd0; m_inst_frozen = 1'b0; m_inst = 32'd0; m_cnt = 32'd0;
        for (int p = 0; p < NR; p++) begin
            m_op_frozen[p] = 1'b0;
            m_op[p] = '0;
        end
    endfunction

    // Advance the model across one clock edge using the inputs of the ending cycle.
    function automatic void model_update();
        exp_t e;
        bit held;
        bit pd;
        logic [DW-1:0] v;
        e    = compute_expected();
        held = stall[1] && stall[2];
        if (e.stallreq && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (held) begin
            if (!m_inst_frozen) begin
                m_inst_frozen = 1'b1;
                m_inst = inst_sram_rdata;
            end
            for (int p = 0; p < NR; p++) begin
                resolve(port_addr(e.id_inst, p), p, pd, v);
                if (!m_op_frozen[p] && !pd) begin
                    m_op_frozen[p] = 1'b1;
                    m_op[p] = v;
                end
            end
        end else begin
            m_inst_frozen = 1'b0;
            for (int p = 0; p < NR; p++) m_op_frozen[p] = 1'b0;
        end
        if (!stall[1]) begin
            m_valid = if_valid;
            m_pc = if_pc;
        end else if (!stall[2]) begin
            m_valid = 1'b0;
            m_pc = 32'd0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (resetn) model_update();
        #1;
    endtask

    task automatic push();
        exp_q.push_back(compute_expected());
    endtask

    task automatic rand_cycle();
        int r;
        tick();
        r = $urandom_range(0, 9);
        stall = {3'($urandom), (r < 5) ? 2'b00 : (r < 8) ? 2'b11 : 2'b01, 1'($urandom)};
        if_valid = ($urandom_range(0, 3) != 0);
        if_pc = $urandom;
        inst_sram_rdata = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        rf_rdata = {$urandom, $urandom};
        rd_used = 2'($urandom);
        for (int i = 0; i < NS; i++) begin
            fwd_we[i] = ($urandom_range(0, 2) != 0);
            fwd_waddr[i*AW +: AW] = 5'($urandom_range(0, 7));
            fwd_wdata[i*DW +: DW] = $urandom;
            fwd_rdy[i] = ($urandom_range(0, 3) != 0);
        end
        push();
    endtask

    // Monitor: compare the DUT against the oldest prediction each falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_valid", 64'(id_valid), 64'(e.id_valid));
                chk("id_pc", 64'(id_pc), 64'(e.id_pc));
                chk("id_inst", 64'(id_inst), 64'(e.id_inst));
                chk("raddr", 64'(raddr), 64'(e.raddr));
                chk("opnd", opnd, e.opnd);
                chk("stallreq", 64'(stallreq), 64'(e.stallreq));
                chk("stall_cnt", 64'(stall_cnt), 64'(e.stall_cnt));
            end
        end
    end

    initial begin : stim
        int guard;
        resetn = 1'b0; stall = ST_RUN; if_valid = 1'b1; if_pc = 32'hBFC0_0000;
        inst_sram_rdata = 32'h1234_5678; rf_rdata = '0; rd_used = '0;
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_rdy = '0;
        model_reset();
        #12;
        @(negedge clk);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_pc", 64'(id_pc), 64'd0);
        chk("rst_id_inst", 64'(id_inst), 64'd0);
        chk("rst_opnd", opnd, 64'd0);
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        resetn = 1'b1;

        tick(); push();
        @(negedge clk);
        chk("first_pc", 64'(id_pc), 64'h0000_0000_BFC0_0000);
        chk("first_valid", 64'(id_valid), 64'd1);

        // Lowest source index wins among equal addresses.
        tick();
        inst_sram_rdata = enc(5'd5, 5'd0); rd_used = 2'b01;
        fwd_we = 3'b101; fwd_waddr = {5'd5, 5'd0, 5'd5};
        fwd_wdata = {32'h22, 32'h0, 32'h11}; fwd_rdy = 3'b111;
        push();
        @(negedge clk);
        chk("fwd_priority", 64'(opnd[31:0]), 64'h11);
        chk("fwd_priority_noreq", 64'(stallreq), 64'd0);

        // Load-use: EX producer not ready, then resolved from MEM.
        tick();
        stall = ST_HOLD; inst_sram_rdata = enc(5'd8, 5'd0); rd_used = 2'b01;
        fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd8}; fwd_wdata = '0; fwd_rdy = 3'b000;
        push();
        @(negedge clk);
        chk("loaduse_req", 64'(stallreq), 64'd1);
        tick();
        fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd8, 5'd0};
        fwd_wdata = {32'h0, 32'hABCD, 32'h0}; fwd_rdy = 3'b010;
        push();
        @(negedge clk);
        chk("loaduse_resolved", 64'(opnd[31:0]), 64'hABCD);
        chk("loaduse_released", 64'(stallreq), 64'd0);

        tick(); stall = ST_RUN; fwd_we = '0; push();

        // r0 always reads zero.
        tick();
        inst_sram_rdata = enc(5'd0, 5'd0); rd_used = 2'b11;
        fwd_we = 3'b001; fwd_waddr = '0; fwd_wdata = {64'h0, 32'hFFFF_FFFF}; fwd_rdy = 3'b111;
        push();
        @(negedge clk);
        chk("r0_zero", opnd, 64'd0);

        // Hold for several cycles while sources retire and SRAM data changes.
        tick();
        stall = ST_HOLD; inst_sram_rdata = enc(5'd3, 5'd4); rf_rdata = {32'h44, 32'h33};
        fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd3, 5'd0};
        fwd_wdata = {32'h0, 32'hAAAA, 32'h0}; fwd_rdy = 3'b111;
        push();
        for (int k = 0; k < 3; k++) begin
            tick();
            inst_sram_rdata = $urandom; rf_rdata = {$urandom, $urandom};
            fwd_we = 3'b110; fwd_waddr = {5'd3, 5'd4, 5'd0};
            fwd_wdata = {32'hBBBB, 32'hCCCC, 32'h0};
            push();
            @(negedge clk);
            chk("hold_inst", 64'(id_inst), 64'(enc(5'd3, 5'd4)));
            chk("hold_opnd0", 64'(opnd[31:0]), 64'hAAAA);
            chk("hold_opnd1", 64'(opnd[63:32]), 64'h44);
        end

        // Bubble empties the slot.
        tick(); stall = ST_BUB; fwd_we = '0; push();
        tick(); stall = ST_RUN; inst_sram_rdata = 32'hDEAD_BEEF; push();
        @(negedge clk);
        chk("bubble_valid", 64'(id_valid), 64'd0);
        chk("bubble_inst", 64'(id_inst), 64'd0);

        // Reset in the middle of a pending hold.
        tick();
        stall = ST_HOLD; inst_sram_rdata = enc(5'd8, 5'd0); rd_used = 2'b01;
        fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd8}; fwd_rdy = 3'b000;
        push();
        @(negedge clk);
        chk("pre_reset_req", 64'(stallreq), 64'd1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", 64'(id_valid), 64'd0);
        chk("midrst_req", 64'(stallreq), 64'd0);
        chk("midrst_opnd", opnd, 64'd0);
        stall = ST_RUN; if_valid = 1'b1; if_pc = 32'h8000_0100; fwd_we = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick(); push();
        @(negedge clk);
        chk("after_rst_pc", 64'(id_pc), 64'h8000_0100);
        chk("after_rst_valid", 64'(id_valid), 64'd1);

        // Four interlock cycles.
        for (int k = 0; k < 4; k++) begin
            tick();
            stall = ST_HOLD; inst_sram_rdata = enc(5'd8, 5'd0); rd_used = 2'b01;
            fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd8}; fwd_rdy = 3'b000;
            push();
        end
        tick(); stall = ST_RUN; fwd_we = '0; push();
        @(negedge clk);
`ifdef ID_STALL_CNT_EN
        chk("stall_cnt_4", 64'(stall_cnt), 64'd4);
`else
        chk("stall_cnt_off", 64'(stall_cnt), 64'd0);
`endif

        for (int n = 0; n < 600; n++) rand_cycle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
